// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the 3x3x3 convolution PE array and its three line buffers.
// Accepts one weight beat, fills the three line buffers, then alternates one CALC cycle
// with one LOAD (row replace) step until every valid output row has been computed once.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   start                      single-cycle layer request, honoured only in IDLE
//   weight_valid/weight_ready  weight beat handshake (ready only in WLOAD)
//   row_valid/row_ready        image row handshake (ready only in FILL and LOAD)
//   PE_en, PE_init_mode        PE array compute enable / weight-load mode
//   mem_wr_en                  one-hot line-buffer write select, qualified by row_valid
//   mem_rd_en                  line-buffer read enables (all three during CALC)
//   top_sel                    buffer holding the oldest kernel row
//   out_valid, out_row         PE result row valid and its index, PE_LAT after PE_en
//   busy, done                 layer in progress / one-cycle completion pulse
//
// Optional feature (macro CONV_SEQ_PERF_EN): adds perf_cycles and perf_stalls counters.
module conv_seq_ctrl #(
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned K      = 3,
    parameter int unsigned PE_LAT = 4,
    parameter int unsigned CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             PE_en,
    output logic             PE_init_mode,
    output logic [2:0]       mem_wr_en,
    output logic [2:0]       mem_rd_en,
    output logic [1:0]       top_sel,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_row,
    output logic             busy,
    output logic             done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [15:0]      perf_cycles,
    output logic [15:0]      perf_stalls
`endif
);

    // Index of the last output row; the CALC carrying it leads to DRAIN.
    localparam logic [CNT_W-1:0] LastCalc  = CNT_W'(IMG_H - K);
    localparam logic [CNT_W-1:0] LastDrain = CNT_W'(PE_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StFill,
        StCalc,
        StLoad,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       top_sel_q, top_sel_d;
    logic [CNT_W-1:0] calc_cnt_q, calc_cnt_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             done_q, done_d;
    logic [PE_LAT-1:0] pipe_vld_q;
    logic [CNT_W-1:0] pipe_row_q [PE_LAT];

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        top_sel_d    = top_sel_q;
        calc_cnt_d   = calc_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        done_d       = 1'b0;
        weight_ready = 1'b0;
        row_ready    = 1'b0;
        PE_en        = 1'b0;
        PE_init_mode = 1'b0;
        mem_wr_en    = 3'b000;
        mem_rd_en    = 3'b000;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StWload;
                    wr_ptr_d    = 2'd0;
                    top_sel_d   = 2'd0;
                    calc_cnt_d  = '0;
                    drain_cnt_d = '0;
                end
            end
            StWload: begin
                PE_init_mode = 1'b1;
                weight_ready = 1'b1;
                if (weight_valid) state_d = StFill;
            end
            StFill: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    mem_wr_en = 3'b001 << wr_ptr_q;
                    wr_ptr_d  = inc3(wr_ptr_q);
                    if (wr_ptr_q == 2'd2) state_d = StCalc;
                end
            end
            StCalc: begin
                PE_en      = 1'b1;
                mem_rd_en  = 3'b111;
                calc_cnt_d = calc_cnt_q + CNT_W'(1);
                if (calc_cnt_q == LastCalc) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    // New row overwrites the oldest; the next-oldest becomes the top row.
                    mem_wr_en = 3'b001 << wr_ptr_q;
                    wr_ptr_d  = inc3(wr_ptr_q);
                    top_sel_d = inc3(wr_ptr_q);
                    state_d   = StCalc;
                end
            end
            StDrain: begin
                if (drain_cnt_q == LastDrain) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= 2'd0;
            top_sel_q   <= 2'd0;
            calc_cnt_q  <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            top_sel_q   <= top_sel_d;
            calc_cnt_q  <= calc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // PE latency model: compute enable and row index travel together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < PE_LAT; i++) pipe_row_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= PE_en;
            pipe_row_q[0] <= calc_cnt_q;
            for (int i = 1; i < PE_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
            end
        end
    end

    assign top_sel   = top_sel_q;
    assign out_valid = pipe_vld_q[PE_LAT-1];
    assign out_row   = pipe_row_q[PE_LAT-1];
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

`ifdef CONV_SEQ_PERF_EN
    logic stall_cycle;
    assign stall_cycle = ((state_q == StLoad) && !row_valid) ||
                         ((state_q == StWload) && !weight_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= 16'd0;
            perf_stalls <= 16'd0;
        end else if ((state_q == StIdle) && start) begin
            // The accepting cycle is counted as the first cycle of the layer.
            perf_cycles <= 16'd1;
            perf_stalls <= 16'd0;
        end else begin
            if (busy && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 16'd1;
            if (stall_cycle && (perf_stalls != 16'hFFFF)) perf_stalls <= perf_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;
    localparam int unsigned IMG_H  = 32;
    localparam int unsigned K      = 3;
    localparam int unsigned PE_LAT = 4;
    localparam int unsigned CNT_W  = 6;
    localparam int NC = IMG_H - K + 1;
    localparam int N  = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, weight_valid = 1'b0, row_valid = 1'b0;
    logic weight_ready, row_ready, PE_en, PE_init_mode, out_valid, busy, done;
    logic [2:0] mem_wr_en, mem_rd_en;
    logic [1:0] top_sel;
    logic [CNT_W-1:0] out_row;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0] perf_cycles, perf_stalls;
    logic [15:0] perf_cyc_at_done = '0, perf_stl_at_done = '0;
`endif

    conv_seq_ctrl #(.IMG_H(IMG_H), .K(K), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .weight_valid(weight_valid), .weight_ready(weight_ready),
        .row_valid(row_valid), .row_ready(row_ready),
        .PE_en(PE_en), .PE_init_mode(PE_init_mode),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .top_sel(top_sel),
        .out_valid(out_valid), .out_row(out_row), .busy(busy), .done(done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus and expected schedule, indexed by cycle relative to the start pulse.
    bit          wv[N], rv[N], st[N];
    logic [12:0] exp_vec[N];
    bit          exp_tc[N];
    int          calc_r[NC];
    int          done_r;

    // Scoreboard queues.
    logic [12:0] ctl_q[$];
    bit          tc_q[$];
    int          ev_cyc_q[$];
    int          ev_row_q[$];
    int          done_q[$];
    int          last_done_cyc = -1000;

    task automatic check(input string name, input int c, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, got, want);
        end
    endtask

    function automatic logic [12:0] pack(input bit b, input bit wr, input bit rr, input bit pe,
                                         input bit init, input logic [2:0] wen,
                                         input logic [2:0] rd, input logic [1:0] top);
        return {b, wr, rr, pe, init, wen, rd, top};
    endfunction

    function automatic logic [2:0] onehot(input int idx);
        logic [2:0] one;
        one = 3'b001;
        return one << (idx % 3);
    endfunction

    function automatic logic [20:0] all_outs();
        return {busy, done, out_valid, out_row, PE_en, PE_init_mode, mem_wr_en, mem_rd_en,
                top_sel, weight_ready, row_ready};
    endfunction

    // Reference schedule: which cycle does what, derived from the handshake rules.
    // The n-th accepted row (counting from 0) lands in buffer n mod 3.
    task automatic build_model();
        int r, rows;
        logic [2:0] wen;
        for (int i = 0; i < N; i++) begin
            exp_vec[i] = '0;
            exp_tc[i]  = 1'b0;
        end
        r = 1;
        while (!wv[r]) begin
            exp_vec[r] = pack(1, 1, 0, 0, 1, 3'b000, 3'b000, 2'd0);
            r++;
        end
        exp_vec[r] = pack(1, 1, 0, 0, 1, 3'b000, 3'b000, 2'd0);
        r++;
        rows = 0;
        while (rows < 3) begin
            wen = rv[r] ? onehot(rows) : 3'b000;
            exp_vec[r] = pack(1, 0, 1, 0, 0, wen, 3'b000, 2'd0);
            if (rv[r]) rows++;
            r++;
        end
        for (int k = 0; k < NC; k++) begin
            exp_vec[r] = pack(1, 0, 0, 1, 0, 3'b000, 3'b111, 2'(k % 3));
            exp_tc[r]  = 1'b1;
            calc_r[k]  = r;
            r++;
            if (k < NC - 1) begin
                while (!rv[r]) begin
                    exp_vec[r] = pack(1, 0, 1, 0, 0, 3'b000, 3'b000, 2'd0);
                    r++;
                end
                exp_vec[r] = pack(1, 0, 1, 0, 0, onehot(rows), 3'b000, 2'd0);
                rows++;
                r++;
            end
        end
        for (int d = 0; d < int'(PE_LAT); d++) begin
            exp_vec[r] = pack(1, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0);
            r++;
        end
        done_r = r;
    endtask

    task automatic set_all_valid();
        for (int i = 0; i < N; i++) begin
            wv[i] = 1'b1;
            rv[i] = 1'b1;
            st[i] = (i == 0);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            wv[i] = (i >= 8) ? 1'b1 : ($urandom_range(0, 2) == 0);
            rv[i] = (i >= 250) ? 1'b1 : ($urandom_range(0, 3) != 0);
            st[i] = (i == 0);
        end
    endtask

    // Extra start pulses while busy must be ignored; one always lands on a CALC cycle.
    task automatic add_random_starts();
        for (int i = 1; i < done_r; i++) if ($urandom_range(0, 15) == 0) st[i] = 1'b1;
        st[calc_r[$urandom_range(0, NC - 1)]] = 1'b1;
    endtask

    task automatic run_layer(input int abort_k, output int base);
        int last;
        last_done_cyc = -1000;
        @(posedge clk);
        #1;
        base = cyc;
        for (int k = 0; k < NC; k++) begin
            if (abort_k < 0 || k < abort_k) begin
                ev_cyc_q.push_back(base + calc_r[k] + int'(PE_LAT));
                ev_row_q.push_back(k);
            end
        end
        if (abort_k < 0) done_q.push_back(base + done_r);
        last = (abort_k < 0) ? done_r + 4 : calc_r[abort_k] + int'(PE_LAT);
        for (int r = 0; r <= last; r++) begin
            if (r > 0) begin
                @(posedge clk);
                #1;
            end
            start        = st[r];
            weight_valid = wv[r];
            row_valid    = rv[r];
            if (abort_k >= 0 && r == last) begin
                #2 rst = 1'b1;
                #1;
                check("reset_mid_layer_outputs", cyc, 32'(all_outs()), 32'd0);
            end else begin
                ctl_q.push_back(exp_vec[r]);
                tc_q.push_back(exp_tc[r]);
            end
        end
        start        = 1'b0;
        weight_valid = 1'b0;
        row_valid    = 1'b0;
        if (abort_k >= 0) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                ctl_q.push_back('0);
                tc_q.push_back(1'b0);
            end
        end
        check("out_events_outstanding", cyc, 32'(ev_cyc_q.size()), 32'd0);
        check("done_events_outstanding", cyc, 32'(done_q.size()), 32'd0);
        ev_cyc_q.delete();
        ev_row_q.delete();
        done_q.delete();
    endtask

    // Monitor: pops per-cycle control expectations and output/done events.
    always @(negedge clk) begin : mon
        logic [12:0] e, act;
        bit tc;
        int ec, er;
        if (ctl_q.size() > 0) begin
            e   = ctl_q.pop_front();
            tc  = tc_q.pop_front();
            act = {busy, weight_ready, row_ready, PE_en, PE_init_mode, mem_wr_en, mem_rd_en,
                   tc ? top_sel : 2'b00};
            check("ctl", cyc, 32'(act), 32'(e));
            check("rd_wr_overlap", cyc, 32'((mem_rd_en != 3'b000) && (mem_wr_en != 3'b000)),
                  32'd0);
        end
        if (out_valid) begin
            if (ev_cyc_q.size() == 0) begin
                check("spurious_out_valid", cyc, 32'd1, 32'd0);
            end else begin
                ec = ev_cyc_q.pop_front();
                er = ev_row_q.pop_front();
                check("out_valid_cycle", cyc, 32'(cyc), 32'(ec));
                check("out_row", cyc, 32'(out_row), 32'(er));
            end
        end
        if (done) begin
            last_done_cyc = cyc;
`ifdef CONV_SEQ_PERF_EN
            perf_cyc_at_done = perf_cycles;
            perf_stl_at_done = perf_stalls;
`endif
            if (done_q.size() == 0) check("spurious_done", cyc, 32'd1, 32'd0);
            else check("done_cycle", cyc, 32'(cyc), 32'(done_q.pop_front()));
        end
    end

    initial begin
        int base;
        rst          = 1'b1;
        start        = 1'b1;
        weight_valid = 1'b1;
        row_valid    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", cyc, 32'(all_outs()), 32'd0);
`ifdef CONV_SEQ_PERF_EN
        check("reset_perf", cyc, {perf_cycles, perf_stalls}, 32'd0);
`endif
        start        = 1'b0;
        weight_valid = 1'b0;
        row_valid    = 1'b0;
        rst          = 1'b0;

        // Nominal run with a stray start during CALC.
        set_all_valid();
        build_model();
        st[calc_r[10]] = 1'b1;
        run_layer(-1, base);
        check("nominal_done_at_68", cyc, 32'(last_done_cyc - base), 32'd68);

        // Five-cycle stall in the LOAD before the 10th CALC.
        set_all_valid();
        for (int r = 22; r <= 26; r++) rv[r] = 1'b0;
        build_model();
        run_layer(-1, base);
        check("stall_done_at_73", cyc, 32'(last_done_cyc - base), 32'd73);
`ifdef CONV_SEQ_PERF_EN
        check("perf_stalls_at_done", cyc, 32'(perf_stl_at_done), 32'd5);
        check("perf_cycles_at_done", cyc, 32'(perf_cyc_at_done), 32'd73);
        check("perf_stalls_hold", cyc, 32'(perf_stalls), 32'd5);
        check("perf_cycles_hold", cyc, 32'(perf_cycles), 32'd73);
`endif

        // Randomised handshakes and stray starts.
        repeat (4) begin
            set_random();
            build_model();
            add_random_starts();
            run_layer(-1, base);
        end

        // Asynchronous reset when out_row 12 would appear, then a clean nominal layer.
        set_random();
        build_model();
        add_random_starts();
        run_layer(12, base);
        set_all_valid();
        build_model();
        run_layer(-1, base);
        check("restart_done_at_68", cyc, 32'(last_done_cyc - base), 32'd68);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
